// File: rtl/count_pkg.sv
// Shared types and defaults for the count sequencer front-end.
// Holds the run/pause state type and counter width.
package count_pkg;

  localparam int COUNT_W       = 4;
  localparam int TICK_DIV_DEF  = 100_000_000;
  localparam int DB_CYCLES_DEF = 1_000_000;

  typedef enum logic {
    PAUSE = 1'b0,
    RUN   = 1'b1
  } state_t;

  typedef struct packed {
    logic run;
    logic dir;
    logic load;
  } btn_t;

endpackage

// File: rtl/btn_conditioner.sv
// Push-button front-end: 2-FF synchronizer, debouncer and
// rising-edge detector producing a one-cycle press pulse.
module btn_conditioner #(
  parameter int DB_CYCLES = 1_000_000
) (
  input  logic clk,
  input  logic reset,
  input  logic i_btn,
  output logic o_press
);

  localparam int CW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(DB_CYCLES - 1);

  logic          r_s1;
  logic          r_s2;
  logic          r_db;
  logic          r_db_q;
  logic [CW-1:0] r_cnt;

  // Counter only runs while the synced level disagrees with
  // the accepted level; any return to agreement restarts it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_db   <= 1'b0;
      r_db_q <= 1'b0;
      r_cnt  <= '0;
    end else begin
      r_s1   <= i_btn;
      r_s2   <= r_s1;
      r_db_q <= r_db;
      if (r_s2 == r_db) begin
        r_cnt <= '0;
      end else if (r_cnt == LAST) begin
        r_db  <= r_s2;
        r_cnt <= '0;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_press = r_db & ~r_db_q;

endmodule

// File: rtl/count_sequencer.sv
// Button-driven paced 4-bit up/down counter with run/pause,
// direction toggle and parallel load; feeds decoder/detector.
module count_sequencer
  import count_pkg::*;
#(
  parameter int TICK_DIV  = TICK_DIV_DEF,
  parameter int DB_CYCLES = DB_CYCLES_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               btn_run,
  input  logic               btn_dir,
  input  logic               btn_load,
  input  logic [COUNT_W-1:0] sw_load,
  output logic [COUNT_W-1:0] count,
  output logic               tick,
  output logic               running,
  output logic               dir_down
);

  localparam int PW = $clog2(TICK_DIV);
  localparam logic [PW-1:0] TERM = PW'(TICK_DIV - 1);

  btn_t               w_press;
  logic               w_term;
  logic               w_step;
  logic [COUNT_W-1:0] w_next;

  state_t             r_state;
  logic [PW-1:0]      r_presc;
  logic [COUNT_W-1:0] r_count;
  logic               r_tick;
  logic               r_dir;

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_run (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_run),
    .o_press(w_press.run)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_dir (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_dir),
    .o_press(w_press.dir)
  );

  btn_conditioner #(.DB_CYCLES(DB_CYCLES)) u_load (
    .clk    (clk),
    .reset  (reset),
    .i_btn  (btn_load),
    .o_press(w_press.load)
  );

  assign w_term = (r_state == RUN) && (r_presc == TERM);
  // Load wins over a coincident step.
  assign w_step = w_term & ~w_press.load;

  always_comb begin
    w_next = r_count;
    unique case (1'b1)
      w_press.load: w_next = sw_load;
      w_step:       w_next = r_dir ? r_count - 1'b1
                                   : r_count + 1'b1;
      default:      w_next = r_count;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= PAUSE;
      r_presc <= '0;
      r_count <= '0;
      r_tick  <= 1'b0;
      r_dir   <= 1'b0;
    end else begin
      r_count <= w_next;
      r_tick  <= (w_next != r_count);
      r_dir   <= r_dir ^ w_press.dir;
      if (w_press.run)
        r_state <= (r_state == RUN) ? PAUSE : RUN;
      if (w_press.run | w_press.load | w_term)
        r_presc <= '0;
      else if (r_state == RUN)
        r_presc <= r_presc + PW'(1);
    end
  end

  assign count    = r_count;
  assign tick     = r_tick;
  assign running  = (r_state == RUN);
  assign dir_down = r_dir;

endmodule

// File: tb/tb_count_sequencer.sv
// Bench for count_sequencer: directed table, corner sequences
// and random button activity against a reference model.
module tb_count_sequencer;

  localparam int TD = 4;
  localparam int DB = 3;

  logic       clk;
  logic       reset;
  logic       btn_run;
  logic       btn_dir;
  logic       btn_load;
  logic [3:0] sw_load;
  logic [3:0] count;
  logic       tick;
  logic       running;
  logic       dir_down;

  int n_chk;
  int n_err;

  count_sequencer #(.TICK_DIV(TD), .DB_CYCLES(DB)) dut (
    .clk     (clk),
    .reset   (reset),
    .btn_run (btn_run),
    .btn_dir (btn_dir),
    .btn_load(btn_load),
    .sw_load (sw_load),
    .count   (count),
    .tick    (tick),
    .running (running),
    .dir_down(dir_down)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout required finish");
    $fatal(1);
  end

  task automatic check(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d required %0d", nm, act, exp);
    end
  endtask

  // Reference model: a press is accepted once the last DB
  // synchronized samples agree on a new level; its effect
  // lands one edge later. Counter steps after TD run cycles.
  bit       m_h [3][8];
  int       m_n [3];
  bit       m_db[3];
  bit       m_rose[3];
  bit       m_p [3];
  int       m_count;
  bit       m_run;
  bit       m_dir;
  bit       m_tick;
  int       m_phase;

  function automatic bit smp(input int b, input int i);
    return (i < m_n[b]) ? m_h[b][i] : 1'b0;
  endfunction

  always @(posedge clk or negedge reset) begin : model
    bit raw[3];
    bit lv;
    bit same;
    bit due;
    int nv;
    if (!reset) begin
      for (int b = 0; b < 3; b++) begin
        m_n[b] = 0; m_db[b] = 0; m_rose[b] = 0;
        for (int j = 0; j < 8; j++) m_h[b][j] = 0;
      end
      m_count = 0; m_run = 0; m_dir = 0; m_tick = 0; m_phase = 0;
    end else begin
      raw[0] = btn_run; raw[1] = btn_dir; raw[2] = btn_load;
      for (int b = 0; b < 3; b++) begin
        m_p[b] = m_rose[b];
        for (int j = 7; j > 0; j--) m_h[b][j] = m_h[b][j-1];
        m_h[b][0] = raw[b];
        if (m_n[b] < 8) m_n[b]++;
        lv = smp(b, 2);
        same = 1;
        for (int j = 0; j < DB; j++)
          if (smp(b, 2 + j) != lv) same = 0;
        m_rose[b] = 0;
        if (same && lv != m_db[b]) begin
          m_db[b] = lv;
          m_rose[b] = lv;
        end
      end
      due = m_run && (m_phase == TD - 1);
      if (m_p[2]) begin
        nv = int'(sw_load);
        m_tick = (nv != m_count);
        m_count = nv;
        m_phase = 0;
      end else if (due) begin
        m_count = (m_count + (m_dir ? 15 : 1)) % 16;
        m_tick = 1;
        m_phase = 0;
      end else begin
        m_tick = 0;
        if (m_run) m_phase++;
      end
      if (m_p[0]) begin
        m_run = !m_run;
        m_phase = 0;
      end
      if (m_p[1]) m_dir = !m_dir;
    end
  end

  typedef struct {
    bit         run;
    bit         dir;
    bit         load;
    logic [3:0] sw;
    int         ncyc;
    int         e_cnt;
    bit         e_run;
    bit         e_dir;
    bit         e_tick;
  } vec_t;

  vec_t tbl[$];
  int   hold[3];
  bit   found;

  initial begin
    n_chk = 0;
    n_err = 0;
    reset = 1'b0;
    btn_run = 0; btn_dir = 0; btn_load = 0; sw_load = 0;

    tbl.push_back('{0,0,0,0,50, 0,0,0,0});
    tbl.push_back('{1,0,0,0, 5, 0,0,0,0});
    tbl.push_back('{1,0,0,0, 1, 0,1,0,0});
    tbl.push_back('{1,0,0,0, 3, 0,1,0,0});
    tbl.push_back('{1,0,0,0, 1, 1,1,0,1});
    tbl.push_back('{0,0,0,0, 1, 1,1,0,0});
    tbl.push_back('{0,0,0,0, 3, 2,1,0,1});
    tbl.push_back('{0,0,0,0,55,15,1,0,0});
    tbl.push_back('{0,0,0,0, 1, 0,1,0,1});
    tbl.push_back('{0,1,0,0, 5, 1,1,0,0});
    tbl.push_back('{0,1,0,0, 1, 1,1,1,0});
    tbl.push_back('{0,0,0,0, 2, 0,1,1,1});
    tbl.push_back('{0,0,0,0, 4,15,1,1,1});
    tbl.push_back('{0,0,0,0, 4,14,1,1,1});
    tbl.push_back('{1,0,0,0, 2,14,1,1,0});
    tbl.push_back('{0,0,0,0, 8,12,1,1,0});
    tbl.push_back('{1,0,0,0, 4,11,1,1,0});
    tbl.push_back('{0,0,0,0, 1,11,1,1,0});
    tbl.push_back('{0,0,0,0, 1,10,0,1,1});
    tbl.push_back('{0,0,0,0,20,10,0,1,0});
    tbl.push_back('{1,0,0,5, 4,10,0,1,0});
    tbl.push_back('{0,0,1,5, 1,10,0,1,0});
    tbl.push_back('{0,0,1,5, 1,10,1,1,0});
    tbl.push_back('{0,0,1,5, 2,10,1,1,0});
    tbl.push_back('{0,0,0,5, 1,10,1,1,0});
    tbl.push_back('{0,0,0,5, 1, 5,1,1,1});
    tbl.push_back('{0,0,0,5, 3, 5,1,1,0});
    tbl.push_back('{0,0,0,5, 1, 4,1,1,1});

    repeat (3) @(negedge clk);
    check("rst_count", count, 0);
    check("rst_running", running, 0);
    check("rst_dir", dir_down, 0);
    check("rst_tick", tick, 0);
    reset = 1'b1;

    foreach (tbl[i]) begin
      btn_run  = tbl[i].run;
      btn_dir  = tbl[i].dir;
      btn_load = tbl[i].load;
      sw_load  = tbl[i].sw;
      repeat (tbl[i].ncyc) @(negedge clk);
      check($sformatf("vec%0d_count", i), count, tbl[i].e_cnt);
      check($sformatf("vec%0d_running", i), running, tbl[i].e_run);
      check($sformatf("vec%0d_dir", i), dir_down, tbl[i].e_dir);
      check($sformatf("vec%0d_tick", i), tick, tbl[i].e_tick);
    end

    // Async reset while running at count 7.
    found = 0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (count == 4'd7) found = 1;
    end
    check("reach_count7", found, 1);
    @(posedge clk);
    #2 reset = 1'b0;
    #1;
    check("async_count", count, 0);
    check("async_running", running, 0);
    check("async_tick", tick, 0);

    // Button held through reset is accepted only after a full
    // debounce window following release.
    btn_dir = 1'b1;
    @(negedge clk);
    reset = 1'b1;
    repeat (5) @(negedge clk);
    check("held_dir_early", dir_down, 0);
    @(negedge clk);
    check("held_dir_late", dir_down, 1);
    btn_dir = 1'b0;
    repeat (10) @(negedge clk);

    // Partial press cut short by reset must be forgotten.
    btn_run = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    btn_run = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);
    check("partial_run", running, 0);
    check("partial_dir", dir_down, 0);

    // Randomized button activity against the model.
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    hold[0] = 0; hold[1] = 0; hold[2] = 0;
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      check($sformatf("rnd%0d_count", c), count, m_count);
      check($sformatf("rnd%0d_tick", c), tick, m_tick);
      check($sformatf("rnd%0d_running", c), running, m_run);
      check($sformatf("rnd%0d_dir", c), dir_down, m_dir);
      for (int b = 0; b < 3; b++) begin
        if (hold[b] == 0) begin
          hold[b] = $urandom_range(1, 9);
          case (b)
            0: btn_run  = $urandom_range(0, 1);
            1: btn_dir  = $urandom_range(0, 1);
            default: btn_load = $urandom_range(0, 1);
          endcase
        end else begin
          hold[b]--;
        end
      end
      sw_load = 4'($urandom_range(0, 15));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
